regex_stream_ctx: RTL and testbench
===================================

REGEX_STREAM_CTX -- requirements
Module: regex_stream_ctx

Interface
REQ-001 SHALL have parameter NUM_STREAMS, default 64, number of per-stream state contexts (power of 2, 2..256).
REQ-002 SHALL have parameter SID_W, default 6, stream id width (= log2 NUM_STREAMS).
REQ-003 SHALL have parameter STATE_W, default 11, matcher state width.
REQ-004 SHALL have parameter CNT_W, default 16, count width.
REQ-005 SHALL have parameter COUNT_MODE, default 0: 0 = count packets with >=1 accept; 1 = count every accept.
REQ-006 Ports, one per line: clk  in  1  clock; rst_n  in  1  synchronous active-low reset, sampled on clk rising edge.
REQ-007 Ports, continued: load_state in 1 packet start; stream_id in SID_W; new_stream_id in 1 force zero state; enable in 1 regex enabled for stream; eop in 1 packet end; clear_all in 1 invalidate all contexts.
REQ-008 Matcher side: m_state_in out STATE_W; m_state_in_vld out 1; m_state_out in STATE_W; m_accept in 1.
REQ-009 Outputs: count out CNT_W; fired out 1 packet-has-match flag; busy out 1 packet in progress; proto_err out 1 sticky protocol error.

Function
REQ-010 SHALL hold per stream a STATE_W context word and a valid bit; invalid contexts read as zero.
REQ-011 FSM states IDLE, ACTIVE; reset -> IDLE; busy = 1 in ACTIVE only.
REQ-012 IDLE + load_state: latch stream_id and enable into sid_q/en_q, go ACTIVE; next cycle m_state_in_vld = 1 for exactly one cycle.
REQ-013 m_state_in = 0 if new_stream_id or context invalid, else stored context word.
REQ-014 Bypass: if load_state samples the stream written by eop in the previous cycle, m_state_in SHALL be that just-written value, never the stale one.
REQ-015 ACTIVE + eop with en_q = 1: write m_state_out to context[sid_q], set valid; add spec_cnt to count; go IDLE.
REQ-016 ACTIVE + eop with en_q = 0: no context write, count unchanged, go IDLE.
REQ-017 spec_cnt cleared on load_state acceptance; each m_accept cycle in ACTIVE: mode 0 sets spec_cnt = 1, mode 1 increments spec_cnt, saturating at all-ones (CNT_W).
REQ-018 m_accept in the same cycle as eop SHALL be included in that packet's count.
REQ-019 count SHALL saturate at 2^CNT_W-1, never wrap.
REQ-020 fired = 1 from first m_accept of packet until next load_state; cleared at eop when en_q = 0.
REQ-021 load_state in ACTIVE without eop: proto_err <= 1, packet restarted per REQ-012 with new id, old context not written.
REQ-022 load_state and eop same cycle in ACTIVE: eop processed first (REQ-015/016), then new packet starts; FSM stays ACTIVE; no proto_err.
REQ-023 eop in IDLE: ignored, proto_err <= 1.
REQ-024 clear_all: all valid bits cleared next cycle; count, FSM unaffected; clear_all with eop same cycle: clear wins for valid bits, eop write of data occurs but valid stays 0.
REQ-025 m_accept in IDLE SHALL be ignored.

Reset
REQ-026 rst_n = 0: FSM IDLE, count = 0, spec_cnt = 0, fired = 0, proto_err = 0, m_state_in_vld = 0, m_state_in = 0, all valid bits = 0.
REQ-027 Context data words need not reset; invalid bits guarantee zero load.
REQ-028 Reset mid-packet abandons packet: no context write, no count update.

Verification
REQ-029 Stream 5, enable=1, two accepts, eop, m_state_out=0x123 -> count +1 (mode 0) or +2 (mode 1); later load stream 5 -> m_state_in = 0x123.
REQ-030 eop on stream 3 (state 0x2A) then load_state stream 3 next cycle -> m_state_in = 0x2A (bypass).
REQ-031 enable=0 packet with accept -> fired clears at eop, count unchanged, context unchanged.
REQ-032 CNT_W=4, mode 1, 20 accepts in a packet -> count = 15, no wrap.
REQ-033 clear_all after saving stream 7, then load stream 7 -> m_state_in = 0.
REQ-034 eop in IDLE and load_state during ACTIVE -> proto_err = 1 and held until reset.

Source files
------------

// File: rtl/regex_stream_ctx_if.sv
// -----------------------------------------------------------------------------
// regex_stream_ctx_if
//   Bundle between a packet source/regex matcher and the per-stream context
//   manager.
//
//   Packet side : load_state, stream_id, new_stream_id, enable, eop, clear_all
//   Matcher side: m_state_in, m_state_in_vld (to matcher),
//                 m_state_out, m_accept (from matcher)
//   Status      : count, fired, busy, proto_err
//
//   modport master : packet source + matcher (drives packet/matcher inputs)
//   modport slave  : context manager (regex_stream_ctx)
// -----------------------------------------------------------------------------
interface regex_stream_ctx_if #(
    parameter int SID_W   = 6,
    parameter int STATE_W = 11,
    parameter int CNT_W   = 16
);
    logic               load_state;
    logic [SID_W-1:0]   stream_id;
    logic               new_stream_id;
    logic               enable;
    logic               eop;
    logic               clear_all;

    logic [STATE_W-1:0] m_state_in;
    logic               m_state_in_vld;
    logic [STATE_W-1:0] m_state_out;
    logic               m_accept;

    logic [CNT_W-1:0]   count;
    logic               fired;
    logic               busy;
    logic               proto_err;

    modport master (
        output load_state, stream_id, new_stream_id, enable, eop, clear_all,
        output m_state_out, m_accept,
        input  m_state_in, m_state_in_vld, count, fired, busy, proto_err
    );

    modport slave (
        input  load_state, stream_id, new_stream_id, enable, eop, clear_all,
        input  m_state_out, m_accept,
        output m_state_in, m_state_in_vld, count, fired, busy, proto_err
    );
endinterface

// File: rtl/regex_stream_ctx.sv
// -----------------------------------------------------------------------------
// regex_stream_ctx
//   Saves and restores the regex matcher state per stream across packets and
//   accumulates a saturating match count over enabled packets.
//
//   Ports:
//     clk    : clock
//     rst_n  : synchronous active-low reset
//     bus    : regex_stream_ctx_if.slave (packet control, matcher state
//              load/save, status outputs)
//
//   Context words live in an array with a registered, enabled read (RAM
//   friendly); valid bits are flops so clear_all takes effect in one cycle.
// -----------------------------------------------------------------------------
module regex_stream_ctx #(
    parameter int NUM_STREAMS = 64,
    parameter int SID_W       = 6,
    parameter int STATE_W     = 11,
    parameter int CNT_W       = 16,
    parameter int COUNT_MODE  = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    regex_stream_ctx_if.slave  bus
);
    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    // Source of the word presented on m_state_in after a load.
    localparam logic [1:0] SEL_ZERO = 2'd0;
    localparam logic [1:0] SEL_MEM  = 2'd1;
    localparam logic [1:0] SEL_FWD  = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t               state_q;
    logic [SID_W-1:0]     sid_q;
    logic                 en_q;
    logic [CNT_W-1:0]     spec_cnt_q;
    logic [CNT_W-1:0]     count_q;
    logic                 fired_q;
    logic                 proto_err_q;
    logic                 vld_q;
    logic [1:0]           ld_sel_q;
    logic [NUM_STREAMS-1:0] valid_q;

    logic [STATE_W-1:0]   ctx_mem [NUM_STREAMS];
    logic [STATE_W-1:0]   rd_data_q;
    logic [STATE_W-1:0]   fwd_data_q;

    logic                 active;
    logic                 accept_now;
    logic                 eop_wr;
    logic                 fwd_hit;
    logic [CNT_W-1:0]     spec_cnt_d;
    logic [CNT_W:0]       count_sum;
    logic [CNT_W-1:0]     count_d;
    logic [1:0]           ld_sel_d;

    always_comb begin
        active     = (state_q == ACTIVE);
        accept_now = active && bus.m_accept;
        // Gate with rst_n so a reset landing on an eop leaves memory untouched.
        eop_wr     = active && bus.eop && en_q && rst_n;

        // Speculative per-packet count including an accept in this cycle, so
        // an accept coincident with eop still lands in the packet total.
        spec_cnt_d = spec_cnt_q;
        if (accept_now) begin
            if (COUNT_MODE == 0) begin
                spec_cnt_d = CNT_W'(1);
            end else if (spec_cnt_q != CNT_MAX) begin
                spec_cnt_d = spec_cnt_q + CNT_W'(1);
            end
        end

        count_sum = {1'b0, count_q} + {1'b0, spec_cnt_d};
        count_d   = count_sum[CNT_W] ? CNT_MAX : count_sum[CNT_W-1:0];

        // Same-cycle eop+load on one stream: RAM read would return the old
        // word, so forward the word being written instead. Previous-cycle
        // writes are already visible in the array.
        fwd_hit = eop_wr && (bus.stream_id == sid_q);
        if (bus.new_stream_id) begin
            ld_sel_d = SEL_ZERO;
        end else if (fwd_hit) begin
            ld_sel_d = bus.clear_all ? SEL_ZERO : SEL_FWD;
        end else if (valid_q[bus.stream_id]) begin
            ld_sel_d = SEL_MEM;
        end else begin
            ld_sel_d = SEL_ZERO;
        end
    end

    // Context storage: no reset, invalid words are masked by valid_q.
    always_ff @(posedge clk) begin
        if (eop_wr) begin
            ctx_mem[sid_q] <= bus.m_state_out;
        end
        if (bus.load_state) begin
            rd_data_q  <= ctx_mem[bus.stream_id];
            fwd_data_q <= bus.m_state_out;
        end
    end

    // Packet FSM and all control/status registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sid_q       <= '0;
            en_q        <= 1'b0;
            spec_cnt_q  <= '0;
            count_q     <= '0;
            fired_q     <= 1'b0;
            proto_err_q <= 1'b0;
            vld_q       <= 1'b0;
            ld_sel_q    <= SEL_ZERO;
            valid_q     <= '0;
        end else begin
            vld_q <= 1'b0;

            // Clear beats a concurrent eop write for the valid bits.
            if (bus.clear_all) begin
                valid_q <= '0;
            end else if (eop_wr) begin
                valid_q[sid_q] <= 1'b1;
            end

            if (accept_now) begin
                spec_cnt_q <= spec_cnt_d;
                fired_q    <= 1'b1;
            end

            unique case (state_q)
                IDLE: begin
                    if (bus.eop) begin
                        proto_err_q <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (bus.eop) begin
                        if (en_q) begin
                            count_q <= count_d;
                        end else begin
                            fired_q <= 1'b0;
                        end
                        state_q <= IDLE;
                    end else if (bus.load_state) begin
                        // Restart without eop: old packet dropped unsaved.
                        proto_err_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // Packet start is handled last so it overrides the eop return to
            // IDLE and the per-packet bookkeeping above.
            if (bus.load_state) begin
                state_q    <= ACTIVE;
                sid_q      <= bus.stream_id;
                en_q       <= bus.enable;
                spec_cnt_q <= '0;
                fired_q    <= 1'b0;
                vld_q      <= 1'b1;
                ld_sel_q   <= ld_sel_d;
            end
        end
    end

    always_comb begin
        unique case (ld_sel_q)
            SEL_MEM: bus.m_state_in = rd_data_q;
            SEL_FWD: bus.m_state_in = fwd_data_q;
            default: bus.m_state_in = '0;
        endcase
    end

    assign bus.m_state_in_vld = vld_q;
    assign bus.count          = count_q;
    assign bus.fired          = fired_q;
    assign bus.busy           = (state_q == ACTIVE);
    assign bus.proto_err      = proto_err_q;

endmodule

// File: tb/tb_regex_stream_ctx.sv
// -----------------------------------------------------------------------------
// tb_regex_stream_ctx
//   Two instances share one stimulus stream: dut0 with default parameters
//   (COUNT_MODE 0, CNT_W 16) and dut1 with COUNT_MODE 1, CNT_W 4 so the
//   saturating count can be reached quickly.
// -----------------------------------------------------------------------------
module tb_regex_stream_ctx;
    localparam int SID_W   = 6;
    localparam int STATE_W = 11;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic               load;
    logic [SID_W-1:0]   sid;
    logic               newsid;
    logic               en;
    logic               eop;
    logic               clr;
    logic [STATE_W-1:0] sout;
    logic               acc;

    regex_stream_ctx_if #(.SID_W(SID_W), .STATE_W(STATE_W), .CNT_W(16)) bus0 ();
    regex_stream_ctx_if #(.SID_W(SID_W), .STATE_W(STATE_W), .CNT_W(4))  bus1 ();

    assign bus0.load_state    = load;
    assign bus0.stream_id     = sid;
    assign bus0.new_stream_id = newsid;
    assign bus0.enable        = en;
    assign bus0.eop           = eop;
    assign bus0.clear_all     = clr;
    assign bus0.m_state_out   = sout;
    assign bus0.m_accept      = acc;

    assign bus1.load_state    = load;
    assign bus1.stream_id     = sid;
    assign bus1.new_stream_id = newsid;
    assign bus1.enable        = en;
    assign bus1.eop           = eop;
    assign bus1.clear_all     = clr;
    assign bus1.m_state_out   = sout;
    assign bus1.m_accept      = acc;

    regex_stream_ctx #(
        .NUM_STREAMS(64), .SID_W(SID_W), .STATE_W(STATE_W), .CNT_W(16), .COUNT_MODE(0)
    ) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.slave)
    );

    regex_stream_ctx #(
        .NUM_STREAMS(64), .SID_W(SID_W), .STATE_W(STATE_W), .CNT_W(4), .COUNT_MODE(1)
    ) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle of packet/matcher stimulus; outputs are checked #1 after edge.
    task automatic drive(input logic l, input logic [SID_W-1:0] s, input logic e,
                         input logic p, input logic [STATE_W-1:0] so, input logic a);
        load = l;
        sid  = s;
        en   = e;
        eop  = p;
        sout = so;
        acc  = a;
        tick();
    endtask

    initial begin
        load = 0; sid = '0; newsid = 0; en = 0; eop = 0; clr = 0; sout = '0; acc = 0;

        // Reset state
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_busy",   32'(bus0.busy), 32'd0);
        check("rst_count0", 32'(bus0.count), 32'd0);
        check("rst_count1", 32'(bus1.count), 32'd0);
        check("rst_fired",  32'(bus0.fired), 32'd0);
        check("rst_perr",   32'(bus0.proto_err), 32'd0);
        check("rst_vld",    32'(bus0.m_state_in_vld), 32'd0);
        check("rst_sin",    32'(bus0.m_state_in), 32'd0);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0);

        // Stream 5, two accepts, save 0x123
        drive(1, 5, 1, 0, 0, 0);
        check("A_busy",       32'(bus0.busy), 32'd1);
        check("A_vld",        32'(bus0.m_state_in_vld), 32'd1);
        check("A_sin_invalid",32'(bus0.m_state_in), 32'd0);
        drive(0, 5, 1, 0, 0, 1);
        check("A_fired",      32'(bus0.fired), 32'd1);
        check("A_vld_pulse",  32'(bus0.m_state_in_vld), 32'd0);
        drive(0, 5, 1, 0, 0, 1);
        drive(0, 5, 1, 1, 11'h123, 0);
        check("A_count0",     32'(bus0.count), 32'd1);
        check("A_count1",     32'(bus1.count), 32'd2);
        check("A_idle",       32'(bus0.busy), 32'd0);
        check("A_fired_hold", 32'(bus0.fired), 32'd1);
        drive(1, 5, 1, 0, 0, 0);
        check("A_reload",     32'(bus0.m_state_in), 32'h123);
        check("A_fired_clr",  32'(bus0.fired), 32'd0);
        drive(0, 5, 1, 1, 11'h123, 0);
        check("A_count0_keep",32'(bus0.count), 32'd1);

        // Bypass: eop on stream 3 then immediate reload
        drive(1, 3, 1, 0, 0, 0);
        drive(0, 3, 1, 1, 11'h02A, 0);
        drive(1, 3, 1, 0, 0, 0);
        check("B_bypass",     32'(bus0.m_state_in), 32'h02A);
        drive(0, 3, 1, 1, 11'h02A, 0);
        newsid = 1;
        drive(1, 3, 1, 0, 0, 0);
        newsid = 0;
        check("B_newsid",     32'(bus0.m_state_in), 32'd0);
        drive(0, 3, 1, 1, 11'h02A, 0);

        // Disabled packet: no save, no count, fired dropped at eop
        drive(1, 5, 0, 0, 0, 0);
        drive(0, 5, 0, 0, 0, 1);
        check("C_fired",      32'(bus0.fired), 32'd1);
        drive(0, 5, 0, 1, 11'h7FF, 0);
        check("C_fired_clr",  32'(bus0.fired), 32'd0);
        check("C_count0",     32'(bus0.count), 32'd1);
        check("C_count1",     32'(bus1.count), 32'd2);
        drive(1, 5, 1, 0, 0, 0);
        check("C_ctx_kept",   32'(bus0.m_state_in), 32'h123);
        drive(0, 5, 1, 1, 11'h123, 0);

        // Accept coincident with eop is counted
        drive(1, 9, 1, 0, 0, 0);
        drive(0, 9, 1, 1, 11'h055, 1);
        check("D_count0",     32'(bus0.count), 32'd2);
        check("D_count1",     32'(bus1.count), 32'd3);

        // clear_all invalidates saved stream 7
        drive(1, 7, 1, 0, 0, 0);
        drive(0, 7, 1, 1, 11'h03C, 0);
        clr = 1;
        drive(0, 0, 0, 0, 0, 0);
        clr = 0;
        drive(1, 7, 1, 0, 0, 0);
        check("E_cleared",    32'(bus0.m_state_in), 32'd0);
        check("E_vld",        32'(bus0.m_state_in_vld), 32'd1);
        drive(0, 7, 1, 1, 11'h111, 0);

        // load_state with eop in ACTIVE: back-to-back packets, no error
        drive(1, 2, 1, 0, 0, 0);
        drive(0, 2, 1, 0, 0, 1);
        drive(1, 4, 1, 1, 11'h0AA, 0);
        check("F_busy",       32'(bus0.busy), 32'd1);
        check("F_perr",       32'(bus0.proto_err), 32'd0);
        check("F_vld",        32'(bus0.m_state_in_vld), 32'd1);
        check("F_sin",        32'(bus0.m_state_in), 32'd0);
        check("F_count0",     32'(bus0.count), 32'd3);
        check("F_count1",     32'(bus1.count), 32'd4);
        check("F_fired",      32'(bus0.fired), 32'd0);
        drive(0, 4, 1, 1, 11'h0BB, 0);
        drive(1, 2, 1, 0, 0, 0);
        check("F_saved",      32'(bus0.m_state_in), 32'h0AA);
        drive(0, 2, 1, 1, 11'h0AA, 0);
        drive(0, 0, 0, 0, 0, 1);
        check("IDLE_acc",     32'(bus0.fired), 32'd0);

        // 20 accepts: dut1 (CNT_W 4, mode 1) saturates at 15
        drive(1, 1, 1, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            drive(0, 1, 1, 0, 0, 1);
        end
        drive(0, 1, 1, 1, 11'h000, 0);
        check("G_count1_sat", 32'(bus1.count), 32'd15);
        check("G_count0",     32'(bus0.count), 32'd4);
        drive(1, 1, 1, 0, 0, 0);
        drive(0, 1, 1, 1, 11'h000, 1);
        check("G_nowrap",     32'(bus1.count), 32'd15);
        check("G_count0_b",   32'(bus0.count), 32'd5);
        check("G_perr_clean", 32'(bus0.proto_err), 32'd0);

        // eop in IDLE raises proto_err
        drive(0, 0, 0, 1, 0, 0);
        check("H_perr_idle",  32'(bus0.proto_err), 32'd1);
        check("H_busy",       32'(bus0.busy), 32'd0);
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        check("H_perr_rst",   32'(bus0.proto_err), 32'd0);
        check("H_count_rst",  32'(bus0.count), 32'd0);

        // Restart without eop raises proto_err, old context not saved
        drive(1, 6, 1, 0, 0, 0);
        drive(1, 8, 1, 0, 0, 0);
        check("H_perr_restart", 32'(bus0.proto_err), 32'd1);
        check("H_restart_vld",  32'(bus0.m_state_in_vld), 32'd1);
        drive(0, 8, 1, 1, 11'h0CC, 0);
        drive(1, 6, 1, 0, 0, 0);
        check("H_no_write",   32'(bus0.m_state_in), 32'd0);
        drive(0, 6, 1, 1, 11'h0DD, 0);
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        check("H_sticky",     32'(bus0.proto_err), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
